// File: rtl/imem_loader.sv
// Fills instruction memory from a host word stream: one registered write per accepted word, 1 word/cycle.
// Write lands the cycle after accept; in_ready only in LOAD; optional IMEM_LOADER_CHECKSUM_EN adds an XOR checksum port.
module imem_loader #(
  parameter int ADDRSIZE = 256,
  parameter int BITWIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BITWIDTH-1:0] base_addr,
  input  logic [BITWIDTH-1:0] length,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] write_addr,
  output logic [BITWIDTH-1:0] write_data,
  output logic                write_valid,
  output logic                busy,
  output logic                core_stall,
  output logic                done,
  output logic                error,
  output logic [BITWIDTH-1:0] words_loaded
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [BITWIDTH-1:0] checksum
`endif
);

  localparam logic [BITWIDTH-1:0] MAX_LEN = BITWIDTH'(ADDRSIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BITWIDTH-1:0] cur_addr;
  logic [BITWIDTH-1:0] remaining;
  logic                load_go;
  logic                zero_go;
  logic                reject;
  logic                accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    load_go    = 1'b0;
    zero_go    = 1'b0;
    reject     = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (length == '0) begin
            zero_go    = 1'b1;
            state_next = S_DONE;
          end else if (length > MAX_LEN) begin
            reject = 1'b1;
          end else begin
            load_go    = 1'b1;
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && remaining == BITWIDTH'(1)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    core_stall = busy;
  end

  // Address wraps modulo 2^BITWIDTH; the memory masks its own index.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr     <= '0;
      remaining    <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_valid  <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      write_valid <= accept;
      error       <= reject;
      if (load_go || zero_go) begin
        cur_addr     <= {base_addr[BITWIDTH-1:2], 2'b00};
        remaining    <= length;
        words_loaded <= '0;
      end
      if (accept) begin
        write_addr   <= cur_addr;
        write_data   <= in_data;
        cur_addr     <= cur_addr + BITWIDTH'(4);
        remaining    <= remaining - BITWIDTH'(1);
        words_loaded <= words_loaded + BITWIDTH'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum <= '0;
    end else if (load_go || zero_go) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum ^ in_data;
    end
  end
`else
  // Checksum accumulator not built in this configuration.
`endif

endmodule
